fpu_issue_ctrl: RTL and testbench
=================================

// Module: fpu_issue_ctrl
// PURPOSE
//  Multi-cycle issue/stall sequencer in the EX stage, directly upstream of the FPU datapath.
//  Decodes fpuOp into the fixed latency of the FPU unit it drives.
//  Drives the FPU clk_en / aclr enable (fpu_sel) and freezes the pipeline while the op is in flight.
//  Pulses fpu_done in the single cycle the FPU result is valid; the EX/MEM register captures it then.
// PARAMETERS
//  LAT_ADD   7   add/sub latency, fpuOp 0,1
//  LAT_MUL   5   multiply latency, fpuOp 2
//  LAT_DIV   6   divide latency, fpuOp 3
//  LAT_CMP   1   compare latency, fpuOp 5 (min/max) and 7 (fle/flt/feq)
//  LAT_SQRT  16  square-root latency, fpuOp 6
//  LAT_CVT   6   convert latency, fpuOp 8,9
//  LAT_FMA   12  fused multiply-add chain latency (mult+add), fpuOp 10..13
//  CNT_W     5   latency counter width; must hold the maximum latency
// PORTS
//  clock            in   1      system clock, rising edge
//  clear            in   1      asynchronous active-high reset
//  ex_fpu_valid     in   1      EX holds a valid FP instruction
//  fpuOp            in   4      FPU operation code from decode
//  flush            in   1      synchronous pipeline flush (branch/trap)
//  fpu_sel          out  1      FPU clock enable; low holds FPU pipelines in aclr
//  fpu_stall        out  1      freeze IF/ID/EX, combinational
//  fpu_done         out  1      FPU result valid this cycle
//  busy             out  1      op in flight (state != IDLE)
//  stall_cycles     out  32     saturating count of cycles with fpu_stall=1
// BEHAVIOUR
//  Latency map lat(op):
//   op 4 (sign-inject) and ops 14,15 map to 0 (combinational, no stall).
//   All other ops map to the parameter for their unit above.
//  start = ex_fpu_valid & ~flush & state==IDLE & lat(fpuOp)!=0.
//  States and transitions:
//   IDLE: on start, latch lat into cnt and go to RUN.
//   RUN: cnt decrements each cycle; when cnt==1, go to DONE.
//   DONE: go to IDLE unconditionally after one cycle.
//  Outputs:
//   fpu_sel is registered, =1 in RUN and DONE; the FPU sees exactly lat enabled edges before DONE.
//   fpu_stall = start | (state==RUN). It is 0 in DONE, so the pipeline advances at the end of DONE.
//   fpu_done = (state==DONE) | (state==IDLE & ex_fpu_valid & ~flush & lat(fpuOp)==0).
//  Timing: an op seen at T0 with latency L stalls T0..TL (L+1 cycles); fpu_sel is high T1..T(L+1); fpu_done pulses at T(L+1).
//  fpuOp is sampled only at start; later changes while RUN are ignored.
//  Back-to-back ops: the next op is seen in IDLE at T(L+2) and fpu_sel is low for that one cycle (FPU aclr). This is required.
//  Flush has priority over everything. Any state goes to IDLE next edge with cnt=0; no fpu_done in the flush cycle or after.
//  Flush in IDLE suppresses both start and the zero-latency done.
//  Reset (any time, including mid-op): state=IDLE, cnt=0, fpu_sel=0, busy=0, stall_cycles=0.
//   fpu_stall and fpu_done follow from this and are 0 unless the inputs request a start or zero-latency op.
//  stall_cycles increments on every cycle with fpu_stall=1 and holds at 32'hFFFFFFFF.
//  Illegal: lat > 2^CNT_W-1 (elaboration check).
// TESTING
//  FADD (op 0) at T0 -> fpu_stall T0..T7, fpu_sel T1..T8, fpu_done only at T8, stall_cycles=8.
//  FSQRT (op 6) -> 17 stall cycles, fpu_done at T17; FMA op 12 -> fpu_done at T13.
//  FSGNJ (op 4) -> fpu_stall=0, fpu_sel=0, fpu_done=1 the same cycle, state stays IDLE.
//  FDIV at T0, flush at T4 -> IDLE at T5, fpu_sel=0 at T5, no fpu_done ever, stall_cycles=5.
//  FMUL then FCVT back-to-back -> done at T6, fpu_sel low at T7, second done at T14.
//  clear asserted mid-FSQRT, async -> outputs zero immediately; next op after release runs normally.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// EX-stage issue/stall sequencer for the FPU: maps fpuOp to a unit latency, gates the FPU
// clock enable, freezes the front of the pipeline while an op is in flight, and flags the result cycle.
module fpu_issue_ctrl #(
  parameter int unsigned LAT_ADD  = 7,
  parameter int unsigned LAT_MUL  = 5,
  parameter int unsigned LAT_DIV  = 6,
  parameter int unsigned LAT_CMP  = 1,
  parameter int unsigned LAT_SQRT = 16,
  parameter int unsigned LAT_CVT  = 6,
  parameter int unsigned LAT_FMA  = 12,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        ex_fpu_valid,
  input  logic [3:0]  fpuOp,
  input  logic        flush,
  output logic        fpu_sel,
  output logic        fpu_stall,
  output logic        fpu_done,
  output logic        busy,
  output logic [31:0] stall_cycles,
  output logic [1:0]  dbg_state
);

  // Handshake: ex_fpu_valid presents an op; the op is accepted in the IDLE cycle where
  // fpu_stall rises, and its result is valid exactly in the cycle fpu_done is high.

  localparam int unsigned MAX_LAT = (1 << CNT_W) - 1;

  if (LAT_ADD > MAX_LAT || LAT_MUL > MAX_LAT || LAT_DIV > MAX_LAT || LAT_CMP > MAX_LAT ||
      LAT_SQRT > MAX_LAT || LAT_CVT > MAX_LAT || LAT_FMA > MAX_LAT) begin : g_lat_chk
    $error("fpu_issue_ctrl: a unit latency does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sel;
  logic [31:0]        r_stall_cnt;

  logic [CNT_W-1:0]   w_lat;
  logic               w_idle;
  logic               w_zero_lat;
  logic               w_start;
  logic               w_stall;
  logic               w_done;

  function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] op);
    logic [CNT_W-1:0] l;
    case (op)
      4'd0, 4'd1:                l = CNT_W'(LAT_ADD);
      4'd2:                      l = CNT_W'(LAT_MUL);
      4'd3:                      l = CNT_W'(LAT_DIV);
      4'd5, 4'd7:                l = CNT_W'(LAT_CMP);
      4'd6:                      l = CNT_W'(LAT_SQRT);
      4'd8, 4'd9:                l = CNT_W'(LAT_CVT);
      4'd10, 4'd11, 4'd12, 4'd13: l = CNT_W'(LAT_FMA);
      default:                   l = '0;  // sign-inject and unused codes are combinational
    endcase
    return l;
  endfunction

  assign w_lat      = lat_of(fpuOp);
  assign w_idle     = (r_state == S_IDLE);
  assign w_zero_lat = (w_lat == '0);
  assign w_start    = ex_fpu_valid & ~flush & w_idle & ~w_zero_lat;
  assign w_stall    = w_start | (r_state == S_RUN);
  // A flush in the DONE cycle kills the result as well as the op.
  assign w_done     = ((r_state == S_DONE) & ~flush) |
                      (w_idle & ex_fpu_valid & ~flush & w_zero_lat);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_cnt   <= w_lat;
            r_sel   <= 1'b1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Dropping fpu_sel here gives the FPU one aclr cycle before any back-to-back op.
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_sel   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_sel   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fpu_sel      = r_sel;
  assign fpu_stall    = w_stall;
  assign fpu_done     = w_done;
  assign busy         = ~w_idle;
  assign stall_cycles = r_stall_cnt;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus random traffic,
// all checked against a timeline model of in-flight ops kept in the bench.
module tb_fpu_issue_ctrl;

  logic        clock = 1'b0;
  logic        clear;
  logic        ex_fpu_valid;
  logic [3:0]  fpuOp;
  logic        flush;
  logic        fpu_sel;
  logic        fpu_stall;
  logic        fpu_done;
  logic        busy;
  logic [31:0] stall_cycles;
  logic [1:0]  dbg_state;

  fpu_issue_ctrl dut (
    .clock        (clock),
    .clear        (clear),
    .ex_fpu_valid (ex_fpu_valid),
    .fpuOp        (fpuOp),
    .flush        (flush),
    .fpu_sel      (fpu_sel),
    .fpu_stall    (fpu_stall),
    .fpu_done     (fpu_done),
    .busy         (busy),
    .stall_cycles (stall_cycles),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Unit latency per opcode, straight from the latency map.
  int lat_tbl [16] = '{7, 7, 5, 6, 0, 1, 16, 1, 6, 6, 12, 12, 12, 12, 0, 0};

  // Reference model: one op in flight, m_k = cycles elapsed since its start cycle.
  bit          m_active;
  int          m_k;
  int          m_lat;
  logic [31:0] m_stall;
  logic        e_sel, e_stall, e_done, e_busy;

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_lat    = 0;
    m_stall  = '0;
  endtask

  task automatic model_eval();
    int  l;
    bit  start_now;
    l         = lat_tbl[fpuOp];
    start_now = !m_active && ex_fpu_valid && !flush && (l != 0);
    e_busy    = m_active;
    e_sel     = m_active;
    e_stall   = start_now || (m_active && m_k <= m_lat);
    e_done    = (m_active && (m_k == m_lat + 1) && !flush) ||
                (!m_active && ex_fpu_valid && !flush && (l == 0));
  endtask

  task automatic model_step();
    if (e_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (flush) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_k == m_lat + 1) m_active = 1'b0;
      else m_k = m_k + 1;
    end else if (e_stall) begin
      m_active = 1'b1;
      m_k      = 1;
      m_lat    = lat_tbl[fpuOp];
    end
  endtask

  // driver: inputs change on the falling edge, outputs are sampled 2ns later
  task automatic set_inputs(input logic v, input logic [3:0] op, input logic fl);
    @(negedge clock);
    ex_fpu_valid = v;
    fpuOp        = op;
    flush        = fl;
    #2;
    model_eval();
  endtask

  task automatic test_reset();
    clear        = 1'b1;
    ex_fpu_valid = 1'b0;
    fpuOp        = 4'd0;
    flush        = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({fpu_sel, fpu_stall, fpu_done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs sel/stall/done/busy got %b exp 0000", {fpu_sel, fpu_stall, fpu_done, busy});
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles);
    end
    @(negedge clock);
    clear = 1'b0;
  endtask

  // One op at T0 held valid until its done cycle; checks cycle-by-cycle and the done/stall totals.
  task automatic test_single_ops();
    int ops [5] = '{0, 6, 12, 4, 7};
    foreach (ops[i]) begin
      int          l;
      int          exp_done_t;
      int          done_t;
      logic [31:0] base;
      logic [3:0]  op;
      op         = 4'(ops[i]);
      l          = lat_tbl[ops[i]];
      exp_done_t = (l == 0) ? 0 : l + 1;
      done_t     = -1;
      base       = m_stall;
      for (int t = 0; t <= exp_done_t + 2; t++) begin
        set_inputs(t <= exp_done_t, op, 1'b0);
        checks++;
        if ({fpu_sel, fpu_stall, fpu_done, busy} !== {e_sel, e_stall, e_done, e_busy}) begin
          errors++;
          $display("FAIL single_op%0d_T%0d sel/stall/done/busy got %b exp %b", op, t,
                   {fpu_sel, fpu_stall, fpu_done, busy}, {e_sel, e_stall, e_done, e_busy});
        end
        checks++;
        if (stall_cycles !== m_stall) begin
          errors++;
          $display("FAIL single_op%0d_T%0d stall_cycles got %0d exp %0d", op, t, stall_cycles, m_stall);
        end
        if (fpu_done === 1'b1 && done_t < 0) done_t = t;
        model_step();
      end
      checks++;
      if (done_t != exp_done_t) begin
        errors++;
        $display("FAIL single_op%0d_done_time got T%0d exp T%0d", op, done_t, exp_done_t);
      end
      checks++;
      if (stall_cycles - base !== 32'((l == 0) ? 0 : l + 1)) begin
        errors++;
        $display("FAIL single_op%0d_stall_total got %0d exp %0d", op, stall_cycles - base, (l == 0) ? 0 : l + 1);
      end
    end
  endtask

  // FDIV at T0, flush at T4: no done ever, 5 stall cycles.
  task automatic test_flush();
    int          n_done;
    logic [31:0] base;
    n_done = 0;
    base   = m_stall;
    for (int t = 0; t < 10; t++) begin
      set_inputs(t <= 4, 4'd3, t == 4);
      checks++;
      if ({fpu_sel, fpu_stall, fpu_done, busy} !== {e_sel, e_stall, e_done, e_busy}) begin
        errors++;
        $display("FAIL flush_T%0d sel/stall/done/busy got %b exp %b", t,
                 {fpu_sel, fpu_stall, fpu_done, busy}, {e_sel, e_stall, e_done, e_busy});
      end
      if (t == 5) begin
        checks++;
        if (fpu_sel !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL flush_idle_T5 sel=%b busy=%b exp 0 0", fpu_sel, busy);
        end
      end
      if (fpu_done === 1'b1) n_done++;
      model_step();
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL flush_no_done got %0d done pulses exp 0", n_done);
    end
    checks++;
    if (stall_cycles - base !== 32'd5) begin
      errors++;
      $display("FAIL flush_stall_total got %0d exp 5", stall_cycles - base);
    end
  endtask

  // FMUL then FCVT back-to-back: done at T6 and T14, fpu_sel low at T7.
  task automatic test_back_to_back();
    int exp_q [$];
    int got_q [$];
    exp_q = '{6, 14};
    for (int t = 0; t < 17; t++) begin
      set_inputs(t <= 14, (t <= 6) ? 4'd2 : 4'd8, 1'b0);
      checks++;
      if ({fpu_sel, fpu_stall, fpu_done, busy} !== {e_sel, e_stall, e_done, e_busy}) begin
        errors++;
        $display("FAIL b2b_T%0d sel/stall/done/busy got %b exp %b", t,
                 {fpu_sel, fpu_stall, fpu_done, busy}, {e_sel, e_stall, e_done, e_busy});
      end
      if (t == 7) begin
        checks++;
        if (fpu_sel !== 1'b0) begin
          errors++;
          $display("FAIL b2b_aclr_T7 fpu_sel got %b exp 0", fpu_sel);
        end
      end
      if (fpu_done === 1'b1) got_q.push_back(t);
      model_step();
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL b2b_done_times got %p exp %p", got_q, exp_q);
    end
  endtask

  // Asynchronous clear in the middle of FSQRT, then a normal FSUB.
  task automatic test_async_clear();
    int done_t;
    for (int t = 0; t < 6; t++) begin
      set_inputs(1'b1, 4'd6, 1'b0);
      model_step();
    end
    @(negedge clock);
    ex_fpu_valid = 1'b0;
    #3;
    clear = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({fpu_sel, fpu_stall, fpu_done, busy} !== 4'b0000 || stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL async_clear sel/stall/done/busy got %b sc %0d exp 0000 sc 0",
               {fpu_sel, fpu_stall, fpu_done, busy}, stall_cycles);
    end
    @(negedge clock);
    clear  = 1'b0;
    done_t = -1;
    for (int t = 0; t < 11; t++) begin
      set_inputs(t <= 8, 4'd1, 1'b0);
      checks++;
      if ({fpu_sel, fpu_stall, fpu_done, busy} !== {e_sel, e_stall, e_done, e_busy} ||
          stall_cycles !== m_stall) begin
        errors++;
        $display("FAIL after_clear_T%0d outs got %b sc %0d exp %b sc %0d", t,
                 {fpu_sel, fpu_stall, fpu_done, busy}, stall_cycles,
                 {e_sel, e_stall, e_done, e_busy}, m_stall);
      end
      if (fpu_done === 1'b1 && done_t < 0) done_t = t;
      model_step();
    end
    checks++;
    if (done_t != 8) begin
      errors++;
      $display("FAIL after_clear_done_time got T%0d exp T8", done_t);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 800; t++) begin
      set_inputs($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
      checks++;
      if ({fpu_sel, fpu_stall, fpu_done, busy} !== {e_sel, e_stall, e_done, e_busy}) begin
        errors++;
        $display("FAIL random_c%0d sel/stall/done/busy got %b exp %b (v=%b op=%0d fl=%b)", t,
                 {fpu_sel, fpu_stall, fpu_done, busy}, {e_sel, e_stall, e_done, e_busy},
                 ex_fpu_valid, fpuOp, flush);
      end
      checks++;
      if (stall_cycles !== m_stall) begin
        errors++;
        $display("FAIL random_c%0d stall_cycles got %0d exp %0d", t, stall_cycles, m_stall);
      end
      model_step();
    end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_flush();
    test_back_to_back();
    test_async_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
